// File: rtl/exc_seq_ctrl.sv
// Exception-entry / ERET sequencer: drain the data bus, issue a one-cycle CP0 update, then redirect fetch.
// Optional drain watchdog is built when the macro EXC_DRAIN_TIMEOUT_EN is defined.
module exc_seq_ctrl #(
   parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
   parameter int unsigned DRAIN_LIMIT = 32'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] pc_i,
   input  logic        in_delayslot_i,
   input  logic [31:0] bad_addr_i,
   input  logic [31:0] epc_i,
   input  logic        mem_busy_i,
   input  logic        fetch_ready_i,
   output logic        stall_o,
   output logic        flush_o,
   output logic        epc_we_o,
   output logic [31:0] epc_o,
   output logic        cause_we_o,
   output logic [4:0]  exccode_o,
   output logic        bd_o,
   output logic        exl_set_o,
   output logic        exl_clr_o,
   output logic        badvaddr_we_o,
   output logic [31:0] badvaddr_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   output logic        drain_timeout_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      COMMIT   = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   localparam logic [4:0] CODE_ADEL = 5'h04;
   localparam logic [4:0] CODE_ADES = 5'h05;
   localparam logic [4:0] CODE_ERET = 5'h0E;

   state_t      state_r;
   logic [4:0]  code_r;
   logic [31:0] pc_r;
   logic        bd_r;
   logic [31:0] bad_addr_r;
   logic [31:0] epc_r;
   logic [31:0] target_r;

   logic [4:0]  code_s;
   logic [31:0] pc_s;
   logic        bd_s;
   logic [31:0] bad_addr_s;
   logic [31:0] epc_s;
   logic        go_commit_s;
   logic        timeout_s;
   logic        drain_expired_s;

   function automatic logic is_recognized(input logic [31:0] code);
      case (code)
         32'h0000_0001, 32'h0000_0004, 32'h0000_0005, 32'h0000_0008,
         32'h0000_0009, 32'h0000_000A, 32'h0000_000C, 32'h0000_000E: is_recognized = 1'b1;
         default:                                                      is_recognized = 1'b0;
      endcase
   endfunction

`ifdef EXC_DRAIN_TIMEOUT_EN
   localparam int unsigned CNT_W = (DRAIN_LIMIT > 32'd1) ? $clog2(DRAIN_LIMIT) : 32'd1;
   logic [CNT_W-1:0] drain_cnt_r;
   assign drain_expired_s = (32'(drain_cnt_r) == (DRAIN_LIMIT - 32'd1));
`else
   localparam int unsigned drain_limit_unused = DRAIN_LIMIT;
   assign drain_expired_s = 1'b0;
`endif

   // In IDLE the commit path sees the live inputs so a direct IDLE->COMMIT entry needs no extra cycle.
   always_comb begin
      go_commit_s = 1'b0;
      timeout_s   = 1'b0;
      if (state_r == IDLE) begin
         code_s     = excepttype_i[4:0];
         pc_s       = pc_i;
         bd_s       = in_delayslot_i;
         bad_addr_s = bad_addr_i;
         epc_s      = epc_i;
      end else begin
         code_s     = code_r;
         pc_s       = pc_r;
         bd_s       = bd_r;
         bad_addr_s = bad_addr_r;
         epc_s      = epc_r;
      end
      case (state_r)
         IDLE: go_commit_s = is_recognized(excepttype_i) && !mem_busy_i;
         DRAIN: begin
            if (!mem_busy_i) begin
               go_commit_s = 1'b1;
            end else if (drain_expired_s) begin
               go_commit_s = 1'b1;
               timeout_s   = 1'b1;
            end else begin
               go_commit_s = 1'b0;
            end
         end
         default: go_commit_s = 1'b0;
      endcase
   end

   // Sequencer state, captured exception context and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= IDLE;
         code_r           <= 5'd0;
         pc_r             <= 32'd0;
         bd_r             <= 1'b0;
         bad_addr_r       <= 32'd0;
         epc_r            <= 32'd0;
         target_r         <= 32'd0;
         stall_o          <= 1'b0;
         flush_o          <= 1'b0;
         busy_o           <= 1'b0;
         epc_we_o         <= 1'b0;
         epc_o            <= 32'd0;
         cause_we_o       <= 1'b0;
         exccode_o        <= 5'd0;
         bd_o             <= 1'b0;
         exl_set_o        <= 1'b0;
         exl_clr_o        <= 1'b0;
         badvaddr_we_o    <= 1'b0;
         badvaddr_o       <= 32'd0;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= 32'd0;
         drain_timeout_o  <= 1'b0;
`ifdef EXC_DRAIN_TIMEOUT_EN
         drain_cnt_r      <= '0;
`endif
      end else begin
         epc_we_o        <= 1'b0;
         epc_o           <= 32'd0;
         cause_we_o      <= 1'b0;
         exccode_o       <= 5'd0;
         bd_o            <= 1'b0;
         exl_set_o       <= 1'b0;
         exl_clr_o       <= 1'b0;
         badvaddr_we_o   <= 1'b0;
         badvaddr_o      <= 32'd0;
         drain_timeout_o <= timeout_s;

         case (state_r)
            IDLE: begin
               if (is_recognized(excepttype_i)) begin
                  code_r     <= excepttype_i[4:0];
                  pc_r       <= pc_i;
                  bd_r       <= in_delayslot_i;
                  bad_addr_r <= bad_addr_i;
                  epc_r      <= epc_i;
                  stall_o    <= 1'b1;
                  flush_o    <= 1'b1;
                  busy_o     <= 1'b1;
                  state_r    <= mem_busy_i ? DRAIN : COMMIT;
               end else begin
                  state_r <= IDLE;
               end
            end
            DRAIN: begin
               if (go_commit_s) begin
                  state_r <= COMMIT;
               end else begin
                  state_r <= DRAIN;
               end
            end
            COMMIT: begin
               state_r          <= REDIRECT;
               redirect_valid_o <= 1'b1;
               redirect_pc_o    <= target_r;
            end
            REDIRECT: begin
               if (fetch_ready_i) begin
                  state_r          <= IDLE;
                  redirect_valid_o <= 1'b0;
                  redirect_pc_o    <= 32'd0;
                  stall_o          <= 1'b0;
                  flush_o          <= 1'b0;
                  busy_o           <= 1'b0;
               end else begin
                  state_r <= REDIRECT;
               end
            end
            default: begin
               state_r          <= IDLE;
               redirect_valid_o <= 1'b0;
               redirect_pc_o    <= 32'd0;
               stall_o          <= 1'b0;
               flush_o          <= 1'b0;
               busy_o           <= 1'b0;
            end
         endcase

         // CP0 strobes land in the COMMIT cycle; ERET only clears EXL and returns to EPC.
         if (go_commit_s) begin
            if (code_s == CODE_ERET) begin
               exl_clr_o <= 1'b1;
               target_r  <= epc_s;
            end else begin
               epc_we_o   <= 1'b1;
               epc_o      <= bd_s ? (pc_s - 32'd4) : pc_s;
               cause_we_o <= 1'b1;
               exccode_o  <= code_s;
               bd_o       <= bd_s;
               exl_set_o  <= 1'b1;
               target_r   <= EXC_VECTOR;
               if ((code_s == CODE_ADEL) || (code_s == CODE_ADES)) begin
                  badvaddr_we_o <= 1'b1;
                  badvaddr_o    <= bad_addr_s;
               end else begin
                  badvaddr_we_o <= 1'b0;
               end
            end
         end

`ifdef EXC_DRAIN_TIMEOUT_EN
         if (state_r == IDLE) begin
            drain_cnt_r <= '0;
         end else if ((state_r == DRAIN) && !go_commit_s) begin
            drain_cnt_r <= drain_cnt_r + CNT_W'(1'b1);
         end else begin
            drain_cnt_r <= drain_cnt_r;
         end
`endif
      end
   end

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Self-checking bench for exc_seq_ctrl: directed plan items plus randomized back-to-back exceptions.
`timescale 1ns/1ps
module tb_exc_seq_ctrl;

   localparam logic [31:0] VEC   = 32'hBFC0_0380;
   localparam int          LIMIT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] excepttype_i, pc_i, bad_addr_i, epc_i;
   logic        in_delayslot_i, mem_busy_i, fetch_ready_i;
   logic        stall_o, flush_o, epc_we_o, cause_we_o, bd_o, exl_set_o, exl_clr_o;
   logic        badvaddr_we_o, redirect_valid_o, drain_timeout_o, busy_o;
   logic [31:0] epc_o, badvaddr_o, redirect_pc_o;
   logic [4:0]  exccode_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   exc_seq_ctrl #(.EXC_VECTOR(VEC), .DRAIN_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .excepttype_i(excepttype_i), .pc_i(pc_i),
      .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i), .epc_i(epc_i),
      .mem_busy_i(mem_busy_i), .fetch_ready_i(fetch_ready_i),
      .stall_o(stall_o), .flush_o(flush_o), .epc_we_o(epc_we_o), .epc_o(epc_o),
      .cause_we_o(cause_we_o), .exccode_o(exccode_o), .bd_o(bd_o),
      .exl_set_o(exl_set_o), .exl_clr_o(exl_clr_o), .badvaddr_we_o(badvaddr_we_o),
      .badvaddr_o(badvaddr_o), .redirect_valid_o(redirect_valid_o),
      .redirect_pc_o(redirect_pc_o), .drain_timeout_o(drain_timeout_o), .busy_o(busy_o)
   );

   logic [111:0] all_outs;
   assign all_outs = {stall_o, flush_o, epc_we_o, epc_o, cause_we_o, exccode_o, bd_o,
                      exl_set_o, exl_clr_o, badvaddr_we_o, badvaddr_o, redirect_valid_o,
                      redirect_pc_o, drain_timeout_o, busy_o};

   logic [5:0] strobes;
   assign strobes = {epc_we_o, cause_we_o, exl_set_o, exl_clr_o, badvaddr_we_o, drain_timeout_o};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one exception and follow it cycle by cycle against the behavioural expectation.
   task automatic run_exc(input logic [31:0] code, input logic [31:0] pc, input logic bd,
                          input logic [31:0] bad, input logic [31:0] epc,
                          input int busy_n, input int rdy);
      logic        eret, bv, exp_to;
      logic [31:0] target, exp_epc;
      int          drain_n;
      eret    = (code == 32'hE);
      bv      = (code == 32'h4) || (code == 32'h5);
      target  = eret ? epc : VEC;
      exp_epc = bd ? (pc - 32'd4) : pc;
      drain_n = busy_n;
      exp_to  = 1'b0;
`ifdef EXC_DRAIN_TIMEOUT_EN
      if (busy_n > LIMIT) begin
         drain_n = LIMIT;
         exp_to  = 1'b1;
      end
`endif
      chk("idle_before", {stall_o, flush_o, busy_o, redirect_valid_o}, 4'b0000);
      excepttype_i   = code;
      pc_i           = pc;
      in_delayslot_i = bd;
      bad_addr_i     = bad;
      epc_i          = epc;
      mem_busy_i     = (busy_n > 0);
      fetch_ready_i  = 1'b0;
      step();
      for (int j = 1; j <= drain_n; j++) begin
         chk("drain_occ", {stall_o, flush_o, busy_o, redirect_valid_o}, 4'b1110);
         chk("drain_strobes", strobes, 6'b0);
         excepttype_i = 32'h8;
         pc_i         = $urandom;
         epc_i        = $urandom;
         mem_busy_i   = (j < busy_n);
         step();
      end
      chk("commit_occ", {stall_o, flush_o, busy_o, redirect_valid_o}, 4'b1110);
      chk("commit_strobes", strobes, {~eret, ~eret, ~eret, eret, bv, exp_to});
      if (!eret) begin
         chk("commit_epc", epc_o, exp_epc);
         chk("commit_exccode", exccode_o, code[4:0]);
         chk("commit_bd", bd_o, bd);
      end
      if (bv) begin
         chk("commit_badvaddr", badvaddr_o, bad);
      end
      excepttype_i  = 32'h9;
      mem_busy_i    = 1'b0;
      fetch_ready_i = (rdy == 0);
      step();
      for (int r = 0; r <= rdy; r++) begin
         chk("redir_valid", {stall_o, flush_o, busy_o, redirect_valid_o}, 4'b1111);
         chk("redir_pc", redirect_pc_o, target);
         chk("redir_strobes", strobes, 6'b0);
         fetch_ready_i = (r >= rdy);
         step();
      end
      excepttype_i  = 32'h0;
      fetch_ready_i = 1'b0;
      chk("idle_after", {stall_o, flush_o, busy_o, redirect_valid_o, redirect_pc_o}, 36'd0);
   endtask

   initial begin
      int codes[8];
      codes = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC, 32'hE};
      rst            = 1'b1;
      excepttype_i   = 32'h8;
      pc_i           = 32'h1234_5678;
      in_delayslot_i = 1'b1;
      bad_addr_i     = 32'h0;
      epc_i          = 32'h0;
      mem_busy_i     = 1'b0;
      fetch_ready_i  = 1'b1;
      repeat (3) step();
      chk("reset_outs", all_outs, 112'd0);
      rst           = 1'b0;
      excepttype_i  = 32'h0;
      fetch_ready_i = 1'b0;
      step();

      run_exc(32'h8, 32'h8000_0100, 1'b0, 32'h0,        32'h0,         0, 0);
      run_exc(32'h4, 32'h8000_0204, 1'b1, 32'h0000_1003, 32'h0,        0, 1);
      run_exc(32'h5, 32'h8000_1000, 1'b0, 32'hDEAD_0001, 32'h0,        5, 0);
      run_exc(32'hE, 32'h8000_0300, 1'b0, 32'h0,        32'h8000_0400, 0, 3);
      run_exc(32'hC, 32'h0000_0000, 1'b1, 32'h0,        32'h0,         2, 2);

      // Unrecognized nonzero codes must leave the block idle.
      excepttype_i = 32'h2;
      step();
      chk("unrec_2", {busy_o, stall_o, flush_o}, 3'b000);
      excepttype_i = 32'h0001_0008;
      step();
      chk("unrec_hi", {busy_o, stall_o, flush_o}, 3'b000);
      excepttype_i = 32'h0;

      // Reset while holding a redirect, then an interrupt.
      excepttype_i = 32'h8;
      pc_i         = 32'h8000_0500;
      step();
      excepttype_i = 32'h0;
      step();
      chk("pre_rst_valid", redirect_valid_o, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_outs", all_outs, 112'd0);
      run_exc(32'h1, 32'h8000_0600, 1'b0, 32'h0, 32'h0, 0, 0);

      // Bus busy well past the drain limit.
      run_exc(32'h5, 32'h8000_0700, 1'b0, 32'h0000_2002, 32'h0, LIMIT + 4, 0);

      for (int k = 0; k < 40; k++) begin
         run_exc(codes[$urandom_range(7)], $urandom, 1'($urandom_range(1)),
                 $urandom, $urandom, $urandom_range(4), $urandom_range(3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
